// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronises and de-glitches an on/off keying envelope, times
// marks and spaces in prescaled ticks, and decodes elements into ASCII characters.
module morse_rx_decoder #(
   parameter int unsigned TICK_DIV     = 7062,
   parameter int unsigned UNIT_TICKS   = 60,
   parameter int unsigned GLITCH_TICKS = 3,
   parameter int unsigned CNT_W        = 10
) (
   input  logic       morse_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       key_clean,
   output logic       overflow,
   output logic       busy
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam int unsigned GW    = $clog2(GLITCH_TICKS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
   localparam logic [GW-1:0]    GLITCH_LAST = GW'(GLITCH_TICKS - 1);
   localparam logic [CNT_W-1:0] DASH_MIN    = CNT_W'(2 * UNIT_TICKS);
   localparam logic [CNT_W-1:0] WORD_GAP    = CNT_W'(5 * UNIT_TICKS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic             key_meta, key_s, key_clean_d;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [GW-1:0]    gcnt;
   logic             rise, fall;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [5:0]       sym, sym_n;
   logic [2:0]       len, len_n;
   logic             bad, bad_n;
   logic             emit;
   logic [7:0]       emit_char;

   // Pattern is right-aligned in sym; the first element sent is bit len-1.
   function automatic logic [7:0] decode(input logic [2:0] l, input logic [5:0] s,
                                         input logic b);
      logic [7:0] c;
      case ({l, s})
         9'b001_000000: c = 8'h45; // E
         9'b001_000001: c = 8'h54; // T
         9'b010_000000: c = 8'h49; // I
         9'b010_000001: c = 8'h41; // A
         9'b010_000010: c = 8'h4E; // N
         9'b010_000011: c = 8'h4D; // M
         9'b011_000000: c = 8'h53; // S
         9'b011_000001: c = 8'h55; // U
         9'b011_000010: c = 8'h52; // R
         9'b011_000011: c = 8'h57; // W
         9'b011_000100: c = 8'h44; // D
         9'b011_000101: c = 8'h4B; // K
         9'b011_000110: c = 8'h47; // G
         9'b011_000111: c = 8'h4F; // O
         9'b100_000000: c = 8'h48; // H
         9'b100_000001: c = 8'h56; // V
         9'b100_000010: c = 8'h46; // F
         9'b100_000100: c = 8'h4C; // L
         9'b100_000110: c = 8'h50; // P
         9'b100_000111: c = 8'h4A; // J
         9'b100_001000: c = 8'h42; // B
         9'b100_001001: c = 8'h58; // X
         9'b100_001010: c = 8'h43; // C
         9'b100_001011: c = 8'h59; // Y
         9'b100_001100: c = 8'h5A; // Z
         9'b100_001101: c = 8'h51; // Q
         9'b101_001111: c = 8'h31;
         9'b101_000111: c = 8'h32;
         9'b101_000011: c = 8'h33;
         9'b101_000001: c = 8'h34;
         9'b101_000000: c = 8'h35;
         9'b101_010000: c = 8'h36;
         9'b101_011000: c = 8'h37;
         9'b101_011100: c = 8'h38;
         9'b101_011110: c = 8'h39;
         9'b101_011111: c = 8'h30;
         default:       c = 8'h2A;
      endcase
      return b ? 8'h2A : c;
   endfunction

   always_ff @(posedge morse_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_meta <= 1'b0;
         key_s    <= 1'b0;
      end else begin
         key_meta <= key_in;
         key_s    <= key_meta;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge morse_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Same persistence requirement on both edges keeps mark/space lengths intact.
   always_ff @(posedge morse_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_clean   <= 1'b0;
         key_clean_d <= 1'b0;
         gcnt        <= '0;
      end else begin
         key_clean_d <= key_clean;
         if (tick) begin
            if (key_s != key_clean) begin
               if (gcnt == GLITCH_LAST) begin
                  key_clean <= key_s;
                  gcnt      <= '0;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end else begin
               gcnt <= '0;
            end
         end
      end
   end

   assign rise    = key_clean & ~key_clean_d;
   assign fall    = ~key_clean & key_clean_d;
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   always_ff @(posedge morse_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sym   <= '0;
         len   <= '0;
         bad   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sym   <= sym_n;
         len   <= len_n;
         bad   <= bad_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      sym_n     = sym;
      len_n     = len;
      bad_n     = bad;
      emit      = 1'b0;
      emit_char = '0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            sym_n = '0;
            len_n = '0;
            bad_n = 1'b0;
            if (rise) state_n = MARK;
         end
         MARK: begin
            if (fall) begin
               if (len == 3'd6) begin
                  bad_n = 1'b1;
               end else begin
                  sym_n = {sym[4:0], (cnt >= DASH_MIN)};
                  len_n = len + 3'd1;
               end
               cnt_n   = '0;
               state_n = SPACE;
            end else if (tick) begin
               cnt_n = cnt_inc;
            end
         end
         SPACE: begin
            if (rise) begin
               cnt_n   = '0;
               state_n = MARK;
            end else if (tick) begin
               cnt_n = cnt_inc;
               if (cnt_inc == DASH_MIN) begin
                  emit      = 1'b1;
                  emit_char = decode(len, sym, bad);
                  sym_n     = '0;
                  len_n     = '0;
                  bad_n     = 1'b0;
               end else if (cnt_inc == WORD_GAP) begin
                  emit      = 1'b1;
                  emit_char = 8'h20;
                  state_n   = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge morse_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         char_data  <= '0;
         char_valid <= 1'b0;
         overflow   <= 1'b0;
      end else if (emit) begin
         if (!char_valid || char_ready) begin
            char_data  <= emit_char;
            char_valid <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (char_valid && char_ready) begin
         char_valid <= 1'b0;
      end
   end

   assign busy = (state == MARK) || (state == SPACE);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder with a 40-cycle Morse unit.
module tb_morse_rx_decoder;

   logic       morse_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       key_in = 1'b0;
   logic       char_ready = 1'b1;
   logic [7:0] char_data;
   logic       char_valid;
   logic       key_clean;
   logic       overflow;
   logic       busy;

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] cap [0:63];
   int         cap_n = 0;
   int         pulse_n = 0;
   logic       valid_q = 1'b0;

   always #5 morse_clk = ~morse_clk;

   morse_rx_decoder #(
      .TICK_DIV(4),
      .UNIT_TICKS(10),
      .GLITCH_TICKS(2),
      .CNT_W(10)
   ) dut (
      .morse_clk(morse_clk),
      .sys_rst_n(sys_rst_n),
      .key_in(key_in),
      .char_data(char_data),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .key_clean(key_clean),
      .overflow(overflow),
      .busy(busy)
   );

   // Record every accepted character and every char_valid pulse.
   always @(negedge morse_clk) begin
      if (sys_rst_n) begin
         if (char_valid && char_ready && cap_n < 64) begin
            cap[cap_n] = char_data;
            cap_n++;
         end
         if (char_valid && !valid_q) pulse_n++;
      end
      valid_q = char_valid;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge morse_clk);
      #1;
   endtask

   task automatic key(input logic lvl, input int n);
      key_in = lvl;
      cycles(n);
   endtask

   // Elements with one-unit gaps; leaves the key low after the last element.
   task automatic send_letter(input string p);
      for (int i = 0; i < p.len(); i++) begin
         key(1'b1, (p[i] == "-") ? 120 : 40);
         if (i != p.len() - 1) key(1'b0, 40);
      end
      key_in = 1'b0;
   endtask

   task automatic test_reset;
      sys_rst_n  = 1'b0;
      key_in     = 1'b1;
      char_ready = 1'b1;
      cycles(20);
      tests_run++;
      if (char_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", char_data); end
      tests_run++;
      if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", char_valid); end
      tests_run++;
      if (key_clean !== 1'b0) begin tests_failed++; $display("FAIL reset_key_clean got %b want 0", key_clean); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      key_in = 1'b0;
      @(negedge morse_clk);
      sys_rst_n = 1'b1;
      cycles(40);
   endtask

   task automatic test_single_dot;
      int base;
      int pb;
      base = cap_n;
      pb   = pulse_n;
      send_letter(".");
      key(1'b0, 300);
      tests_run++;
      if (cap_n - base !== 2) begin tests_failed++; $display("FAIL dot_count got %0d want 2", cap_n - base); end
      tests_run++;
      if (cap[base] !== 8'h45) begin tests_failed++; $display("FAIL dot_char got %h want 45", cap[base]); end
      tests_run++;
      if (cap[base+1] !== 8'h20) begin tests_failed++; $display("FAIL dot_space got %h want 20", cap[base+1]); end
      tests_run++;
      if (pulse_n - pb !== 2) begin tests_failed++; $display("FAIL dot_pulses got %0d want 2", pulse_n - pb); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL dot_busy got %b want 0", busy); end
   endtask

   task automatic test_sos;
      logic [7:0] exp [0:3];
      int base;
      exp = '{8'h53, 8'h4F, 8'h53, 8'h20};
      base = cap_n;
      send_letter("...");
      key(1'b0, 120);
      send_letter("---");
      key(1'b0, 120);
      send_letter("...");
      key(1'b0, 280);
      cycles(40);
      tests_run++;
      if (cap_n - base !== 4) begin tests_failed++; $display("FAIL sos_count got %0d want 4", cap_n - base); end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (cap[base+i] !== exp[i]) begin
            tests_failed++;
            $display("FAIL sos_char%0d got %h want %h", i, cap[base+i], exp[i]);
         end
      end
   endtask

   task automatic test_glitch;
      int base;
      base = cap_n;
      key(1'b1, 60);
      key(1'b0, 4);
      key(1'b1, 60);
      key(1'b0, 40);
      key(1'b1, 4);
      key(1'b0, 100);
      key(1'b1, 4);
      key(1'b0, 300);
      tests_run++;
      if (cap_n - base !== 2) begin tests_failed++; $display("FAIL glitch_count got %0d want 2", cap_n - base); end
      tests_run++;
      if (cap[base] !== 8'h54) begin tests_failed++; $display("FAIL glitch_char got %h want 54", cap[base]); end
      tests_run++;
      if (cap[base+1] !== 8'h20) begin tests_failed++; $display("FAIL glitch_space got %h want 20", cap[base+1]); end
   endtask

   task automatic test_bad_patterns;
      int base;
      base = cap_n;
      send_letter("-------");
      key(1'b0, 300);
      send_letter(".-.-");
      key(1'b0, 300);
      tests_run++;
      if (cap_n - base !== 4) begin tests_failed++; $display("FAIL bad_count got %0d want 4", cap_n - base); end
      tests_run++;
      if (cap[base] !== 8'h2A) begin tests_failed++; $display("FAIL seven_dash got %h want 2a", cap[base]); end
      tests_run++;
      if (cap[base+2] !== 8'h2A) begin tests_failed++; $display("FAIL unlisted got %h want 2a", cap[base+2]); end
      tests_run++;
      if (cap[base+3] !== 8'h20) begin tests_failed++; $display("FAIL bad_space got %h want 20", cap[base+3]); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL bad_overflow got %b want 0", overflow); end
   endtask

   task automatic test_overflow;
      int base;
      base = cap_n;
      char_ready = 1'b0;
      send_letter(".");
      key(1'b0, 120);
      send_letter("-");
      key(1'b0, 300);
      tests_run++;
      if (char_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_valid got %b want 1", char_valid); end
      tests_run++;
      if (char_data !== 8'h45) begin tests_failed++; $display("FAIL ovf_data got %h want 45", char_data); end
      tests_run++;
      if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
      tests_run++;
      if (cap_n - base !== 0) begin tests_failed++; $display("FAIL ovf_early got %0d want 0", cap_n - base); end
      char_ready = 1'b1;
      cycles(3);
      tests_run++;
      if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drain_valid got %b want 0", char_valid); end
      tests_run++;
      if (char_data !== 8'h45) begin tests_failed++; $display("FAIL ovf_hold_data got %h want 45", char_data); end
      tests_run++;
      if (cap_n - base !== 1 || cap[base] !== 8'h45) begin
         tests_failed++;
         $display("FAIL ovf_accept got n=%0d c=%h want n=1 c=45", cap_n - base, cap[base]);
      end
      tests_run++;
      if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_reset_mid_char;
      int base;
      send_letter("-.");
      key(1'b0, 40);
      key(1'b1, 60);
      sys_rst_n = 1'b0;
      cycles(10);
      tests_run++;
      if ({char_data, char_valid, key_clean, overflow, busy} !== 12'h000) begin
         tests_failed++;
         $display("FAIL midrst_outputs got d=%h v=%b k=%b o=%b b=%b want all 0",
                  char_data, char_valid, key_clean, overflow, busy);
      end
      key_in = 1'b0;
      @(negedge morse_clk);
      sys_rst_n = 1'b1;
      base = cap_n;
      cycles(40);
      send_letter(".-");
      key(1'b0, 300);
      tests_run++;
      if (cap_n - base !== 2) begin tests_failed++; $display("FAIL midrst_count got %0d want 2", cap_n - base); end
      tests_run++;
      if (cap[base] !== 8'h41) begin tests_failed++; $display("FAIL midrst_char got %h want 41", cap[base]); end
      tests_run++;
      if (cap[base+1] !== 8'h20) begin tests_failed++; $display("FAIL midrst_space got %h want 20", cap[base+1]); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL midrst_overflow got %b want 0", overflow); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) cap[i] = 8'hxx;
      test_reset;
      test_single_dot;
      test_sos;
      test_glitch;
      test_bad_patterns;
      test_overflow;
      test_reset_mid_char;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
